// File: rtl/apb4_master_bridge_if.sv
// rtl/apb4_master_bridge_if.sv - command/response port and APB4 bus signals of apb4_master_bridge
interface apb4_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL1;
  logic                  PSEL2;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY1;
  logic                  PREADY2;
  logic [DATA_WIDTH-1:0] PRDATA1;
  logic [DATA_WIDTH-1:0] PRDATA2;
  logic                  PSLVERR1;
  logic                  PSLVERR2;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY1, PREADY2, PRDATA1, PRDATA2, PSLVERR1, PSLVERR2
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY1, PREADY2, PRDATA1, PRDATA2, PSLVERR1, PSLVERR2
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// rtl/apb4_master_bridge.sv - valid/ready command port to APB4 SETUP/ACCESS transfers on two slave selects
// Optional ACCESS timeout is enabled by defining APB4_MST_TIMEOUT_EN.
module apb4_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_BIT        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb4_master_bridge_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (((DATA_WIDTH % 8) != 0) || (SEL_BIT >= ADDR_WIDTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb4_master_bridge: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  psel1_q, psel1_d;
  logic                  psel2_q, psel2_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  cmd_ready;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
`endif

  assign cmd_ready = (state_q == IDLE) && PRESETn;

  // Only the selected slave is listened to; the other one's PREADY is ignored.
  assign sel_ready = psel2_q ? bus.PREADY2  : bus.PREADY1;
  assign sel_err   = psel2_q ? bus.PSLVERR2 : bus.PSLVERR1;
  assign sel_rdata = psel2_q ? bus.PRDATA2  : bus.PRDATA1;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB4_MST_TIMEOUT_EN
    acc_cnt_d   = acc_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        if (bus.cmd_valid && cmd_ready) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          psel1_d  = ~bus.cmd_addr[SEL_BIT];
          psel2_d  = bus.cmd_addr[SEL_BIT];
          state_d  = SETUP;
`ifdef APB4_MST_TIMEOUT_EN
          acc_cnt_d = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
          rsp_err_d   = sel_err;
          state_d     = IDLE;
        end
`ifdef APB4_MST_TIMEOUT_EN
        // A PREADY in the last allowed cycle takes the branch above, so the slave wins the tie.
        else if (acc_cnt_q == CNT_LIMIT) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      acc_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB4_MST_TIMEOUT_EN
      acc_cnt_q   <= acc_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL1     = psel1_q;
  assign bus.PSEL2     = psel2_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
